// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and types for the 7-segment scan monitor.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package sseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

endpackage

// File: rtl/sseg_hex_dec.sv
// sseg_hex_dec: maps one captured active-low segment pattern back to a hex
// nibble. Unknown patterns decode to nibble 0 with valid low.
module sseg_hex_dec
  import sseg_pkg::*;
(
  input  seg_t       seg,
  output logic [3:0] nib,
  output logic       valid,
  output logic       blank
);

  // Table lookup; the all-off pattern is reported separately as blank.
  always_comb begin
    nib   = 4'h0;
    valid = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0: nib = 4'h0;
      SEG_1: nib = 4'h1;
      SEG_2: nib = 4'h2;
      SEG_3: nib = 4'h3;
      SEG_4: nib = 4'h4;
      SEG_5: nib = 4'h5;
      SEG_6: nib = 4'h6;
      SEG_7: nib = 4'h7;
      SEG_8: nib = 4'h8;
      SEG_9: nib = 4'h9;
      SEG_A: nib = 4'hA;
      SEG_B: nib = 4'hB;
      SEG_C: nib = 4'hC;
      SEG_D: nib = 4'hD;
      SEG_E: nib = 4'hE;
      SEG_F: nib = 4'hF;
      SEG_BLANK: begin
        valid = 1'b0;
        blank = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_rx.sv
// sseg_scan_rx: monitor for a multiplexed 4-digit 7-segment bus.
// Synchronizes {an,sseg,dp}, waits for a stable dwell, then latches the
// pattern of the single active digit and decodes it.
// Optional build macro SSEG_SCAN_RX_TIMEOUT_EN adds per-digit staleness
// watchdogs that force a digit to blank/invalid when it stops refreshing.
module sseg_scan_rx
  import sseg_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int TIMEOUT_W     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  input  logic        dp,
  output logic [15:0] hex,
  output logic [27:0] seg_cap,
  output logic [3:0]  dp_cap,
  output logic [3:0]  valid,
  output logic [3:0]  blank,
  output logic        upd,
  output logic        err
);

  // The counter value one below the fire point: capture happens on the edge
  // where the count steps onto STABLE_CYCLES-1.
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 2);

  logic [11:0] sync1, sync2, prev;
  logic [7:0]  stab_cnt;
  logic [3:0]  an_s;
  seg_t        sseg_s;
  logic        dp_s;
  logic        same, cap_fire, cap_one;
  logic [1:0]  cap_idx;
  seg_t        seg_q [NUM_DIGITS];
  logic [3:0]  dp_q;
  logic        upd_pend;
  logic [3:0]  dec_valid, dec_blank, stale;

  assign an_s     = sync2[11:8];
  assign sseg_s   = sync2[7:1];
  assign dp_s     = sync2[0];
  assign same     = (sync2 == prev);
  assign cap_fire = same && (stab_cnt == CNT_FIRE);

  // Two-flop synchronizer plus a one-cycle history for change detection;
  // resets to the idle (all-off) bus so a driven bus after reset counts as a change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {an, sseg, dp};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Stability counter: restart on any change, otherwise count up and saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stab_cnt <= '0;
    else if (!same)
      stab_cnt <= '0;
    else if (stab_cnt < CNT_MAX)
      stab_cnt <= stab_cnt + 8'd1;
  end

  // Identify the single active-low anode, if exactly one is driven.
  always_comb begin
    cap_one = 1'b0;
    cap_idx = 2'd0;
    case (an_s)
      4'b1110: begin cap_one = 1'b1; cap_idx = 2'd0; end
      4'b1101: begin cap_one = 1'b1; cap_idx = 2'd1; end
      4'b1011: begin cap_one = 1'b1; cap_idx = 2'd2; end
      4'b0111: begin cap_one = 1'b1; cap_idx = 2'd3; end
      default: ;
    endcase
  end

  // Capture registers and a delayed change flag so upd trails the capture edge by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIGITS; d++) seg_q[d] <= SEG_BLANK;
      dp_q     <= '1;
      upd_pend <= 1'b0;
      upd      <= 1'b0;
    end else begin
      upd_pend <= 1'b0;
      upd      <= upd_pend;
      if (cap_fire && cap_one) begin
        seg_q[cap_idx] <= sseg_s;
        dp_q[cap_idx]  <= dp_s;
        upd_pend       <= (seg_q[cap_idx] != sseg_s) || (dp_q[cap_idx] != dp_s);
      end
    end
  end

  // Sticky error when a stable dwell shows more than one anode driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (cap_fire && !cap_one && (an_s != 4'hF))
      err <= 1'b1;
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    sseg_hex_dec u_dec (
      .seg   (seg_q[d]),
      .nib   (hex[4*d +: 4]),
      .valid (dec_valid[d]),
      .blank (dec_blank[d])
    );
    assign seg_cap[7*d +: 7] = seg_q[d];
  end

  assign dp_cap = dp_q;
  assign valid  = dec_valid & ~stale;
  assign blank  = dec_blank | stale;

`ifdef SSEG_SCAN_RX_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog [NUM_DIGITS];

  // Per-digit refresh watchdogs: cleared by that digit's capture, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NUM_DIGITS; d++) wdog[d] <= '0;
    end else begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (cap_fire && cap_one && (cap_idx == 2'(d)))
          wdog[d] <= '0;
        else if (wdog[d] != '1)
          wdog[d] <= wdog[d] + 1'b1;
      end
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_stale
    assign stale[d] = &wdog[d];
  end
`else
  logic unused_timeout_w;
  assign unused_timeout_w = (TIMEOUT_W > 0);
  assign stale = '0;
`endif

endmodule

// File: tb/tb_sseg_scan_rx.sv
// tb_sseg_scan_rx: directed self-checking bench for sseg_scan_rx.
// Inputs change just after the falling edge; outputs are sampled on the
// falling edge, half a cycle after the rising edge that updates them.
module tb_sseg_scan_rx;

  localparam logic [6:0] P_1  = 7'b1111001;
  localparam logic [6:0] P_2  = 7'b0100100;
  localparam logic [6:0] P_3  = 7'b0110000;
  localparam logic [6:0] P_5  = 7'b0010010;
  localparam logic [6:0] P_8  = 7'b0000000;
  localparam logic [6:0] P_A  = 7'b0001000;
  localparam logic [6:0] P_F  = 7'b0001110;
  localparam logic [6:0] P_BL = 7'b1111111;
  localparam logic [6:0] P_XX = 7'b1010101;

`ifdef SSEG_SCAN_RX_TIMEOUT_EN
  localparam int TW = 8;
`else
  localparam int TW = 20;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic [15:0] hex;
  logic [27:0] seg_cap;
  logic [3:0]  dp_cap;
  logic [3:0]  valid;
  logic [3:0]  blank;
  logic        upd;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_cnt = 0;
  int upd_base;
  int first_upd;

  sseg_scan_rx #(.STABLE_CYCLES(16), .TIMEOUT_W(TW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .an      (an),
    .sseg    (sseg),
    .dp      (dp),
    .hex     (hex),
    .seg_cap (seg_cap),
    .dp_cap  (dp_cap),
    .valid   (valid),
    .blank   (blank),
    .upd     (upd),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle upd is seen high.
  always @(negedge clk) if (upd === 1'b1) upd_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an   = a;
    sseg = s;
    dp   = d;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".hex"},     32'(hex),     32'h0);
    chk({tag, ".seg_cap"}, 32'(seg_cap), 32'h0FFF_FFFF);
    chk({tag, ".dp_cap"},  32'(dp_cap),  32'hF);
    chk({tag, ".valid"},   32'(valid),   32'h0);
    chk({tag, ".blank"},   32'(blank),   32'hF);
    chk({tag, ".upd"},     32'(upd),     32'h0);
    chk({tag, ".err"},     32'(err),     32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    an    = 4'hF;
    sseg  = P_BL;
    dp    = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    hold(4'hF, P_BL, 1'b1, 20);

`ifdef SSEG_SCAN_RX_TIMEOUT_EN
    // Capture digit 2, then stop refreshing it long past 2^8 cycles.
    hold(4'b1011, P_3, 1'b1, 30);
    chk("to.valid_pre", 32'(valid[2]), 32'h1);
    hold(4'b1110, P_1, 1'b1, 300);
    chk("to.valid2", 32'(valid[2]), 32'h0);
    chk("to.blank2", 32'(blank[2]), 32'h1);
    chk("to.seg2",   32'(seg_cap[20:14]), 32'(P_3));
`else
    // First capture: exact latency of the capture edge and of upd.
    upd_base  = upd_cnt;
    first_upd = 0;
    an = 4'b1110; sseg = P_5; dp = 1'b1;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 17) chk("t1.valid_c17", 32'(valid), 32'h0);
      if (i == 18) begin
        chk("t1.valid_c18", 32'(valid), 32'h1);
        chk("t1.hex_c18",   32'(hex),   32'h0005);
      end
      if (upd === 1'b1 && first_upd == 0) first_upd = i;
    end
    chk("t1.upd_cycle", 32'(first_upd), 32'd19);
    chk("t1.upd_count", 32'(upd_cnt - upd_base), 32'd1);

    // Rotation 1, A, blank, F; blank over blank gives no upd.
    upd_base = upd_cnt;
    hold(4'b1110, P_1,  1'b1, 64);
    hold(4'b1101, P_A,  1'b1, 64);
    hold(4'b1011, P_BL, 1'b1, 64);
    hold(4'b0111, P_F,  1'b0, 64);
    hold(4'hF,    P_BL, 1'b1, 30);
    chk("rot.hex",     32'(hex),     32'h0000_F0A1);
    chk("rot.valid",   32'(valid),   32'b1011);
    chk("rot.blank",   32'(blank),   32'b0100);
    chk("rot.dp_cap",  32'(dp_cap),  32'b0111);
    chk("rot.seg_cap", 32'(seg_cap), 32'({P_F, P_BL, P_A, P_1}));
    chk("rot.upd_n",   32'(upd_cnt - upd_base), 32'd3);

    // Short glitches are never captured, including a 15-cycle dwell.
    upd_base = upd_cnt;
    hold(4'b1110, P_8, 1'b1, 10);
    hold(4'b1110, P_1, 1'b1, 40);
    chk("gl10.hex0", 32'(hex[3:0]), 32'h1);
    hold(4'b1110, P_8, 1'b1, 15);
    hold(4'hF, P_BL, 1'b1, 30);
    chk("gl15.hex0", 32'(hex[3:0]), 32'h1);
    chk("gl.upd_n",  32'(upd_cnt - upd_base), 32'd0);

    // A 16-cycle dwell is long enough.
    hold(4'b1110, P_8, 1'b1, 16);
    hold(4'hF, P_BL, 1'b1, 30);
    chk("dw16.hex0",  32'(hex[3:0]), 32'h8);
    chk("dw16.upd_n", 32'(upd_cnt - upd_base), 32'd1);

    // Unrecognized pattern on digit 1.
    hold(4'b1101, P_XX, 1'b1, 30);
    hold(4'hF, P_BL, 1'b1, 10);
    chk("bad.hex",   32'(hex),   32'h0000_F008);
    chk("bad.valid", 32'(valid), 32'b1001);
    chk("bad.blank", 32'(blank), 32'b0100);

    // Two anodes low: error, no capture; sticky through later idle.
    upd_base = upd_cnt;
    hold(4'b1100, P_3, 1'b1, 32);
    chk("err.set",     32'(err),     32'h1);
    chk("err.seg_cap", 32'(seg_cap), 32'({P_F, P_BL, P_XX, P_8}));
    chk("err.upd_n",   32'(upd_cnt - upd_base), 32'd0);
    hold(4'hF, P_BL, 1'b1, 20);
    chk("err.sticky",  32'(err),     32'h1);

    // Reset at stability count 10, then a full count after release.
    hold(4'b1110, P_2, 1'b1, 13);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 17) chk("rr.valid_c17", 32'(valid), 32'h0);
      if (i == 18) begin
        chk("rr.valid_c18", 32'(valid), 32'h1);
        chk("rr.hex_c18",   32'(hex),   32'h0002);
      end
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
